// File: rtl/sr_ff_pkg.sv
// Shared types and SR command encodings for the set/reset flip-flop driver
// and the flip-flop side of the board.
package sr_ff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_INVALID = 2'b11;

    // Only ever yields SET or RESET, so the invalid command cannot be built.
    function automatic logic [1:0] sr_cmd(input logic level);
        return level ? SR_SET : SR_RESET;
    endfunction

endpackage

// File: rtl/sr_pulse_counter.sv
// Wrapping pulse counter with synchronous clear, used for the set and reset
// pulse tallies shown on the board LEDs.
module sr_pulse_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sr_ff_driver.sv
// Initiator for an external SR flip-flop: pulses s/r, reads q back, retries
// on mismatch and latches a sticky error after repeated failures.
module sr_ff_driver
    import sr_ff_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_level,
    input  logic             req_force,
    output logic             req_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             done,
    output logic             err,
    input  logic             clr_err,
    output logic             busy,
    output logic             shadow,
    output logic [CNT_W-1:0] set_count,
    output logic [CNT_W-1:0] reset_count
);

    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state, state_n;
    logic          level, level_n;
    logic          shadow_n;
    logic [SW-1:0] settle, settle_n;
    logic [RW-1:0] retry, retry_n;
    logic [1:0]    cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            level  <= 1'b0;
            shadow <= 1'b0;
            settle <= '0;
            retry  <= '0;
        end else begin
            state  <= state_n;
            level  <= level_n;
            shadow <= shadow_n;
            settle <= settle_n;
            retry  <= retry_n;
        end
    end

    always_comb begin
        state_n  = state;
        level_n  = level;
        shadow_n = shadow;
        settle_n = settle;
        retry_n  = retry;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    level_n = req_level;
                    if (req_level != shadow || req_force) begin
                        state_n = PULSE;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            PULSE: begin
                settle_n = '0;
                state_n  = SETTLE;
            end
            SETTLE: begin
                if (settle == SW'(SETTLE_CYCLES - 1)) begin
                    state_n = CHECK;
                end else begin
                    settle_n = settle + SW'(1);
                end
            end
            CHECK: begin
                if (q_fb == level) begin
                    shadow_n = level;
                    retry_n  = '0;
                    state_n  = DONE;
                end else if (retry < RW'(MAX_RETRY)) begin
                    retry_n = retry + RW'(1);
                    state_n = PULSE;
                end else begin
                    state_n = ERROR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERROR: begin
                // Resync to whatever the flip-flop actually holds.
                if (clr_err) begin
                    shadow_n = q_fb;
                    retry_n  = '0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd       = (state == PULSE) ? sr_cmd(level) : SR_HOLD;
    assign s         = cmd[1];
    assign r         = cmd[0];
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == ERROR);

    sr_pulse_counter #(.CNT_W(CNT_W)) u_set_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (s),
        .count (set_count)
    );

    sr_pulse_counter #(.CNT_W(CNT_W)) u_reset_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (r),
        .count (reset_count)
    );

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver: cycle tables plus retry, reset and
// long alternating-request sequences against an SR flip-flop model.
module tb_sr_ff_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_level, req_force, clr_err;
    logic       req_ready, s, r, done, err, busy, shadow;
    logic       q_fb, ff_q, stuck;
    logic [7:0] set_count, reset_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sr_ff_driver #(
        .SETTLE_CYCLES (2),
        .MAX_RETRY     (3),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_level   (req_level),
        .req_force   (req_force),
        .req_ready   (req_ready),
        .s           (s),
        .r           (r),
        .q_fb        (q_fb),
        .done        (done),
        .err         (err),
        .clr_err     (clr_err),
        .busy        (busy),
        .shadow      (shadow),
        .set_count   (set_count),
        .reset_count (reset_count)
    );

    always @(posedge clk) begin
        if (rst) ff_q <= 1'b0;
        else if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end

    assign q_fb = stuck ? 1'b0 : ff_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(s && r))
            else begin
                $display("FAIL s_r_exclusive: s=%0b r=%0b required not both 1", s, r);
                miscompares++;
            end
        end
    end

    // inputs: valid lvl force clr | outputs: rdy s r done err busy shadow | set | reset
    typedef struct packed {
        logic [3:0] in;
        logic [6:0] flags;
        logic [7:0] sc;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl [23];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] outs();
        return {req_ready, s, r, done, err, busy, shadow, set_count, reset_count};
    endfunction

    task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got rdy,s,r,done,err,busy,sh=%b set=%0d rst=%0d, required %b set=%0d rst=%0d",
                     nm, act[22:16], act[15:8], act[7:0], exp[22:16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic chk1(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_level = 1'b0; req_force = 1'b0; clr_err = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int err_cyc;
        int act;
        logic lvl;

        tbl[0]  = {4'b1100, 7'b0100010, 8'd0, 8'd0};
        tbl[1]  = {4'b0000, 7'b0000010, 8'd1, 8'd0};
        tbl[2]  = {4'b0000, 7'b0000010, 8'd1, 8'd0};
        tbl[3]  = {4'b0000, 7'b0000010, 8'd1, 8'd0};
        tbl[4]  = {4'b0000, 7'b0001011, 8'd1, 8'd0};
        tbl[5]  = {4'b0000, 7'b1000001, 8'd1, 8'd0};
        tbl[6]  = {4'b1100, 7'b0001011, 8'd1, 8'd0};
        tbl[7]  = {4'b0000, 7'b1000001, 8'd1, 8'd0};
        tbl[8]  = {4'b1110, 7'b0100011, 8'd1, 8'd0};
        tbl[9]  = {4'b0000, 7'b0000011, 8'd2, 8'd0};
        tbl[10] = {4'b0000, 7'b0000011, 8'd2, 8'd0};
        tbl[11] = {4'b0000, 7'b0000011, 8'd2, 8'd0};
        tbl[12] = {4'b0000, 7'b0001011, 8'd2, 8'd0};
        tbl[13] = {4'b0000, 7'b1000001, 8'd2, 8'd0};
        tbl[14] = {4'b1000, 7'b0010011, 8'd2, 8'd0};
        tbl[15] = {4'b1110, 7'b0000011, 8'd2, 8'd1};
        tbl[16] = {4'b1110, 7'b0000011, 8'd2, 8'd1};
        tbl[17] = {4'b0000, 7'b0000011, 8'd2, 8'd1};
        tbl[18] = {4'b0000, 7'b0001010, 8'd2, 8'd1};
        tbl[19] = {4'b0000, 7'b1000000, 8'd2, 8'd1};
        tbl[20] = {4'b0001, 7'b1000000, 8'd2, 8'd1};
        tbl[21] = {4'b1000, 7'b0001010, 8'd2, 8'd1};
        tbl[22] = {4'b0000, 7'b1000000, 8'd2, 8'd1};

        stuck = 1'b0;
        do_reset;
        chk("reset_state", outs(), {7'b1000000, 8'd0, 8'd0});

        for (int i = 0; i < 23; i++) begin
            {req_valid, req_level, req_force, clr_err} = tbl[i].in;
            step;
            chk($sformatf("row%0d", i), outs(), {tbl[i].flags, tbl[i].sc, tbl[i].rc});
        end
        req_valid = 1'b0; req_level = 1'b0; req_force = 1'b0; clr_err = 1'b0;

        // Flip-flop stuck at 0: first pulse plus three retries, then ERROR.
        do_reset;
        stuck = 1'b1;
        req_valid = 1'b1; req_level = 1'b1;
        step;
        req_valid = 1'b0; req_level = 1'b0;
        pulses = 0;
        err_cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            if (s) pulses++;
            if (err && err_cyc < 0) err_cyc = c;
            if (c == 20) clr_err = 1'b0;
            step;
        end
        chk1("stuck_pulses", pulses, 4);
        chk1("stuck_err_cycle", err_cyc, 17);
        chk("stuck_err_state", outs(), {7'b0000110, 8'd4, 8'd0});
        clr_err = 1'b1;
        step;
        clr_err = 1'b0;
        chk("clr_err_idle", outs(), {7'b1000000, 8'd4, 8'd0});
        stuck = 1'b0;

        // Reset while in SETTLE.
        do_reset;
        req_valid = 1'b1; req_level = 1'b1;
        step;
        req_valid = 1'b0;
        chk("rst_mid_pulse", outs(), {7'b0100010, 8'd0, 8'd0});
        step;
        chk("rst_mid_settle", outs(), {7'b0000010, 8'd1, 8'd0});
        rst = 1'b1;
        step;
        chk("rst_mid_after", outs(), {7'b1000000, 8'd0, 8'd0});
        rst = 1'b0;
        act = 0;
        for (int c = 0; c < 10; c++) begin
            if (s || r) act++;
            step;
        end
        chk1("rst_mid_no_pulses", act, 0);
        chk("rst_mid_quiet", outs(), {7'b1000000, 8'd0, 8'd0});

        // 300 alternating requests.
        do_reset;
        for (int i = 0; i < 300; i++) begin
            lvl = (i % 2 == 0);
            req_valid = 1'b1; req_level = lvl;
            step;
            req_valid = 1'b0;
            act = 0;
            while (!done && act < 20) begin
                step;
                act++;
            end
            chk1($sformatf("alt%0d_done", i), int'(done), 1);
            step;
        end
        chk("alt_counts", outs(), {7'b1000000, 8'd150, 8'd150});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Initiator side of the set/reset flip-flop interface. Accepts requested output levels over a valid/ready handshake and drives mutually exclusive one-cycle `s`/`r` pulses into an SR flip-flop on the same clock. It then reads the flip-flop's `q` back, retries on mismatch, and raises a sticky error after repeated failures. It sits between switch/control logic and the flip-flop on the board top level, and keeps set/reset pulse counts for LED display.

## Interface
- `SETTLE_CYCLES`, default 2: cycles waited after a pulse before sampling `q_fb`; legal range ≥ 1.
- `MAX_RETRY`, default 3: re-pulses allowed after the first mismatch before entering ERROR; legal range ≥ 0.
- `CNT_W`, default 8: width of the pulse counters.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_level`  in  1  requested flip-flop state.
- `req_force`  in  1  issue a pulse even when `req_level` equals the shadow state.
- `req_ready`  out  1  high only in IDLE.
- `s`  out  1  set pulse to the flip-flop.
- `r`  out  1  reset pulse to the flip-flop.
- `q_fb`  in  1  flip-flop `q`, read back.
- `done`  out  1  one-cycle completion strobe.
- `err`  out  1  sticky failure flag.
- `clr_err`  in  1  clears ERROR.
- `busy`  out  1  high when not in IDLE.
- `shadow`  out  1  last confirmed flip-flop state.
- `set_count`  out  `CNT_W`  number of set pulses issued.
- `reset_count`  out  `CNT_W`  number of reset pulses issued.

## Operation
- States and transitions:
  - IDLE: accept when `req_valid & req_ready`.
    - If `req_level != shadow` or `req_force` is high, latch the level and go to PULSE.
    - Otherwise go to DONE (skip path).
  - PULSE: assert `s` if the latched level is 1, or `r` if it is 0, for exactly one cycle. Increment the matching counter. Go to SETTLE.
  - SETTLE: count `SETTLE_CYCLES` cycles, then go to CHECK.
  - CHECK: compare `q_fb` with the latched level.
    - Match: set `shadow` to the level, clear the retry count, go to DONE.
    - Mismatch with retry count < `MAX_RETRY`: increment the retry count, go to PULSE.
    - Mismatch otherwise: go to ERROR.
  - DONE: `done` = 1 for one cycle, then IDLE.
  - ERROR: `err` = 1 and `req_ready` = 0. On `clr_err`, set `shadow` to `q_fb`, clear the retry count, go to IDLE. `clr_err` is ignored in all other states.
- Invariant: `s` and `r` are never high together; the 2'b11 command is never produced.
- Counters wrap modulo 2^`CNT_W`. Retries count as pulses.
- `req_level` and `req_force` are sampled only on the accept cycle; changes afterwards are ignored.
- Reset at any point, including mid-operation: state goes to IDLE. `s`, `r`, `done`, `err`, `busy`, `shadow`, both counters and the retry count all go to 0. This matches the flip-flop's reset value of 0.
- Reset values of outputs: `req_ready` = 1 from the first cycle after reset; every other output = 0.

## Timing
- Cycle 0 is the accept cycle (IDLE).
- Pulse path:
  - cycle 1: PULSE (`s` or `r` high).
  - cycles 2 to 1+`SETTLE_CYCLES`: SETTLE. The flip-flop's `q` changes after the cycle-1 edge.
  - cycle 2+`SETTLE_CYCLES`: CHECK.
  - cycle 3+`SETTLE_CYCLES`: DONE.
  - cycle 4+`SETTLE_CYCLES`: IDLE, `req_ready` high.
- Each retry adds 2+`SETTLE_CYCLES` cycles (PULSE, SETTLE, CHECK).
- Skip path: DONE at cycle 1, IDLE at cycle 2. No `s`/`r` activity and no counter change.
- `q_fb` is sampled only in CHECK; glitches in other states have no effect.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to `s`/`r`.

## Structure
- Shared package `sr_ff_pkg`:
  - state enum `{IDLE, PULSE, SETTLE, CHECK, DONE, ERROR}`.
  - SR command constants: `SR_HOLD`=2'b00, `SR_RESET`=2'b01, `SR_SET`=2'b10, `SR_INVALID`=2'b11. The flip-flop side uses the same constants.
- Sub-module `sr_pulse_counter`: a `CNT_W`-bit wrapping counter with synchronous clear. It is instantiated twice, once for set pulses and once for reset pulses.

## Test plan
- Reset, then request level=1 with an ideal flip-flop model, `SETTLE_CYCLES`=2 → `s` high for exactly cycle 1; `done` at cycle 5; `shadow`=1; `set_count`=1; `reset_count`=0.
- With `shadow`=1: request level=1, force=0 → no pulse, `done` at cycle 1, counters unchanged. The same request with force=1 → `s` pulses and `set_count`=2.
- `q_fb` stuck at 0, request level=1, `MAX_RETRY`=3 → 4 `s` pulses, then `err`=1 and `req_ready`=0, `set_count`=4. `clr_err` → IDLE next cycle, `shadow`=0.
- Assert `rst` during SETTLE → next cycle all outputs 0, `req_ready`=1, no further `s`/`r` pulses.
- 300 alternating requests, `CNT_W`=8 → `set_count`=150 and `reset_count`=150 (each wraps past 255 only if exceeded); `s` & `r` never high together (assertion for the whole run).
